e_mdu: RTL and testbench

//  E-stage multiply/divide unit with architectural HI/LO registers. Executes MULT/MULTU/DIV/DIVU
//  as fixed-latency multi-cycle ops, and MTHI/MTLO as single-cycle writes. It also exposes HI/LO
//  for MFHI/MFLO. The E-stage result mux forwards HI/LO into E_outputA of the EX/MEM register.

---
 rtl/e_mdu_if.sv | 27 ++
 rtl/e_mdu.sv | 152 +++++++++++++++
 tb/tb_e_mdu.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Bundle of the E-stage md request inputs and the HI/LO/busy observation outputs.
// The pipeline side (master) drives the request; the e_mdu (slave) drives status and results.
interface e_mdu_if;
    // Handshake: an md_op is accepted at a rising edge when start & ~Req & ~busy.
    // busy acts as the inverse of ready. An op that is not accepted leaves no trace,
    // so the requester must hold start until busy is low.
    logic        Req;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_act;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [1:0]  dbg_state;

    modport master (
        output Req, start, md_op, A, B,
        input  busy, md_act, HI, LO, dbg_state
    );

    modport slave (
        input  Req, start, md_op, A, B,
        output busy, md_act, HI, LO, dbg_state
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers.
// MULT/DIV results come from the latched operands and are committed after a fixed busy window.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   md
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        is_mul;
    logic        is_div_s;
    logic        mul_s;
    logic        div_zero;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    // The datapath only sees latched operands, so it may be treated as a multicycle path
    // whose depth is bounded by the busy window.
    always_comb begin
        is_mul   = (op_q == OP_MULT) || (op_q == OP_MULTU);
        mul_s    = (op_q == OP_MULT);
        is_div_s = (op_q == OP_DIV);
        div_zero = (b_q == 32'd0);

        ext_a = mul_s ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = mul_s ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;

        // Signed division runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        mag_a = (is_div_s && a_q[31]) ? (32'd0 - a_q) : a_q;
        mag_b = (is_div_s && b_q[31]) ? (32'd0 - b_q) : b_q;
        uq    = div_zero ? 32'd0 : (mag_a / mag_b);
        ur    = div_zero ? 32'd0 : (mag_a % mag_b);
        quo   = (is_div_s && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
        rem   = (is_div_s && a_q[31]) ? (32'd0 - ur) : ur;
    end

    assign accept = md.start & ~md.Req & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (md.md_op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = md.A;
                            b_d     = md.B;
                            op_d    = md.md_op;
                            cnt_d   = MULT_N;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = md.A;
                            b_d     = md.B;
                            op_d    = md.md_op;
                            cnt_d   = DIV_N;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = md.A;
                        OP_MTLO: lo_d = md.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = 4'(cnt_q - 4'd1);
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (is_mul) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy      = (state_q == S_RUN);
    assign md.md_act    = md.start | md.busy;
    assign md.HI        = hi_q;
    assign md.LO        = lo_q;
    assign md.dbg_state = state_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: a reference model pushes expected {HI,LO} per accepted op,
// and each completion pops and compares.
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;

    e_mdu_if md ();

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint sa, sb, q, r;
        case (op)
            3'd0: return longint'($signed(a)) * longint'($signed(b));
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {hi, lo};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for busy to drop; already_seen counts busy cycles consumed by the caller.
    task automatic wait_done(input string tag, input int exp_n, input int already_seen);
        int n;
        logic [63:0] e;
        n = already_seen;
        while (md.busy && n < 40) begin
            if (n == 1) chk({tag, "_hold"}, {md.HI, md.LO}, {model_hi, model_lo});
            tick();
            n++;
        end
        chk({tag, "_busylen"}, 64'(n), 64'(exp_n));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_hilo"}, {md.HI, md.LO}, e);
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
    endtask

    // Driver for an op issued while the unit is idle.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic req);
        md.start = 1'b1;
        md.md_op = op;
        md.A     = a;
        md.B     = b;
        md.Req   = req;
        #1;
        chk({tag, "_act"}, 64'(md.md_act), 64'd1);
        tick();
        md.start = 1'b0;
        md.Req   = 1'b0;
        if (!req && op <= 3'd3) begin
            exp_q.push_back(ref_md(op, a, b, model_hi, model_lo));
            wait_done(tag, (op <= 3'd1) ? MULT_N : DIV_N, 0);
        end else begin
            if (!req && op == 3'd4) model_hi = a;
            if (!req && op == 3'd5) model_lo = a;
            chk({tag, "_busy"}, 64'(md.busy), 64'd0);
            chk({tag, "_hilo"}, {md.HI, md.LO}, {model_hi, model_lo});
        end
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        reset    = 1'b1;
        md.Req   = 1'b0;
        md.start = 1'b0;
        md.md_op = 3'd0;
        md.A     = 32'd0;
        md.B     = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 64'(md.busy), 64'd0);
        chk("rst_act", 64'(md.md_act), 64'd0);
        chk("rst_hilo", {md.HI, md.LO}, 64'd0);

        issue("t1_mult", 3'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        chk("t1_const", {md.HI, md.LO}, 64'hFFFFFFFF_FFFFFFF1);

        issue("t2_divu", 3'd3, 32'd7, 32'd2, 1'b0);
        chk("t2_const", {md.HI, md.LO}, 64'h00000001_00000003);
        issue("t2_div", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("t2s_const", {md.HI, md.LO}, 64'hFFFFFFFF_FFFFFFFD);

        issue("t3_mthi", 3'd4, 32'h11, 32'd0, 1'b0);
        issue("t3_mtlo", 3'd5, 32'h22, 32'd0, 1'b0);
        issue("t3_div0", 3'd2, 32'd9, 32'd0, 1'b0);
        chk("t3_const", {md.HI, md.LO}, 64'h00000011_00000022);

        issue("t4_req", 3'd0, 32'd2, 32'd3, 1'b1);
        issue("t4_noreq", 3'd0, 32'd2, 32'd3, 1'b0);
        chk("t4_const", {md.HI, md.LO}, 64'h00000000_00000006);

        issue("ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_const", {md.HI, md.LO}, 64'h00000000_80000000);
        issue("rsvd", 3'd6, 32'h55, 32'h66, 1'b0);

        // Ops offered while busy, plus a Req pulse, must not disturb the running MULT.
        md.start = 1'b1; md.md_op = 3'd0; md.A = 32'd12345; md.B = 32'hFFFFFF00;
        exp_q.push_back(ref_md(3'd0, 32'd12345, 32'hFFFFFF00, model_hi, model_lo));
        tick();
        md.md_op = 3'd5; md.A = 32'hAA; md.B = 32'd0;
        #1;
        chk("t5_act", 64'(md.md_act), 64'd1);
        tick();
        md.md_op = 3'd0; md.A = 32'd7; md.B = 32'd7;
        tick();
        md.start = 1'b0;
        md.Req   = 1'b1;
        tick();
        md.Req   = 1'b0;
        chk("t5_midhold", {md.HI, md.LO}, {model_hi, model_lo});
        wait_done("t5", MULT_N, 3);

        // Reset in busy cycle 3 of a DIVU drops the pending result.
        md.start = 1'b1; md.md_op = 3'd3; md.A = 32'd100; md.B = 32'd7;
        tick();
        md.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        chk("t6_busy", 64'(md.busy), 64'd0);
        chk("t6_hilo", {md.HI, md.LO}, 64'd0);
        repeat (15) tick();
        chk("t6_nowrite", {md.HI, md.LO}, 64'd0);
        issue("t6_multu", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("t6_const", {md.HI, md.LO}, 64'h00000001_FFFFFFFE);

        for (int i = 0; i < 14; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 5) begin r_op = 3'd2; r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
            issue("rnd", r_op, r_a, r_b, ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
